// File: rtl/geri_yaz_hakem.sv
// Write-back arbiter: merges pipeline results with a 2-entry queue of long-latency
// unit results onto one register-file write port, raising a stall when the queue starves.
module geri_yaz_hakem #(
    parameter int unsigned BEKLEME_ESIGI = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        gy_gecerli_i,
    input  logic [4:0]  gy_adres_i,
    input  logic [31:0] gy_deger_i,
    input  logic        uzun_gecerli_i,
    input  logic [4:0]  uzun_adres_i,
    input  logic [31:0] uzun_deger_i,
    output logic        uzun_hazir_o,
    input  logic [4:0]  cz_rs1_adres_i,
    input  logic [4:0]  cz_rs2_adres_i,
    output logic        cz_bekliyor_o,
    output logic        cyo_durdur_o,
    output logic [4:0]  cyo_yaz_adres_o,
    output logic [31:0] cyo_yaz_deger_o,
    output logic        cyo_yaz_yazmac_o
);

    typedef enum logic [1:0] {BOS, BEKLE, DURDUR} durum_t;

    typedef struct packed {
        logic [4:0]  adres;
        logic [31:0] deger;
    } kayit_t;

    localparam logic [2:0] ESIK = 3'(BEKLEME_ESIGI);

    durum_t      durum_q, durum_d;
    logic [2:0]  sayac_q, sayac_d;
    logic [1:0]  sayi_q, sayi_d;
    logic        bas_gecerli_q, bas_gecerli_d;
    logic        arka_gecerli_q, arka_gecerli_d;
    kayit_t      bas_q, bas_d;
    kayit_t      arka_q, arka_d;
    logic        yaz_yazmac_q, yaz_yazmac_d;
    logic [4:0]  yaz_adres_q, yaz_adres_d;
    logic [31:0] yaz_deger_q, yaz_deger_d;

    logic   gy_izin;
    logic   yeni_gecerli;
    kayit_t yeni;
    logic   cek;
    logic   bas_kal;
    logic   arka_kal;

    assign uzun_hazir_o     = (sayi_q < 2'd2);
    assign cyo_durdur_o     = (durum_q == DURDUR);
    assign cyo_yaz_yazmac_o = yaz_yazmac_q;
    assign cyo_yaz_adres_o  = yaz_adres_q;
    assign cyo_yaz_deger_o  = yaz_deger_q;

    assign cz_bekliyor_o =
        (bas_gecerli_q && (bas_q.adres != 5'd0) &&
         ((bas_q.adres == cz_rs1_adres_i) || (bas_q.adres == cz_rs2_adres_i))) ||
        (arka_gecerli_q && (arka_q.adres != 5'd0) &&
         ((arka_q.adres == cz_rs1_adres_i) || (arka_q.adres == cz_rs2_adres_i)));

    // Queue datapath: pop, drop entries overwritten by a younger pipeline write, compact, append.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        bas_d          = bas_q;
        arka_d         = arka_q;
        bas_gecerli_d  = 1'b0;
        arka_gecerli_d = 1'b0;

        gy_izin      = gy_gecerli_i && (gy_adres_i != 5'd0);
        yeni.adres   = uzun_adres_i;
        yeni.deger   = uzun_deger_i;
        yeni_gecerli = uzun_gecerli_i && uzun_hazir_o && (uzun_adres_i != 5'd0) &&
                       !(gy_izin && (uzun_adres_i == gy_adres_i));
        cek          = !gy_izin && (sayi_q != 2'd0);
        bas_kal      = bas_gecerli_q && !cek && !(gy_izin && (bas_q.adres == gy_adres_i));
        arka_kal     = arka_gecerli_q && !(gy_izin && (arka_q.adres == gy_adres_i));

        if (bas_kal) begin
            bas_gecerli_d = 1'b1;
            if (arka_kal) begin
                arka_gecerli_d = 1'b1;
            end else begin
                arka_d         = yeni;
                arka_gecerli_d = yeni_gecerli;
            end
        end else if (arka_kal) begin
            bas_d          = arka_q;
            bas_gecerli_d  = 1'b1;
            arka_d         = yeni;
            arka_gecerli_d = yeni_gecerli;
        end else begin
            bas_d         = yeni;
            bas_gecerli_d = yeni_gecerli;
        end

        sayi_d = {1'b0, bas_gecerli_d} + {1'b0, arka_gecerli_d};

        yaz_yazmac_d = 1'b0;
        yaz_adres_d  = yaz_adres_q;
        yaz_deger_d  = yaz_deger_q;
        if (gy_izin) begin
            yaz_yazmac_d = 1'b1;
            yaz_adres_d  = gy_adres_i;
            yaz_deger_d  = gy_deger_i;
        end else if (cek) begin
            yaz_yazmac_d = 1'b1;
            yaz_adres_d  = bas_q.adres;
            yaz_deger_d  = bas_q.deger;
        end
    end

    // Starvation FSM: the counter measures how long the queue head has been denied.
    always_comb begin
        durum_d = durum_q;
        sayac_d = sayac_q;
        unique case (durum_q)
            BOS: begin
                if (yeni_gecerli) begin
                    durum_d = BEKLE;
                    sayac_d = 3'd0;
                end
            end
            BEKLE: begin
                if (cek) begin
                    sayac_d = 3'd0;
                end else begin
                    sayac_d = sayac_q + 3'd1;
                    if (sayac_d == ESIK) durum_d = DURDUR;
                end
            end
            DURDUR: begin
                if (cek) begin
                    durum_d = BEKLE;
                    sayac_d = 3'd0;
                end
            end
            default: begin
                durum_d = BOS;
                sayac_d = 3'd0;
            end
        endcase
        if (sayi_d == 2'd0) begin
            durum_d = BOS;
            sayac_d = 3'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q        <= BOS;
            sayac_q        <= 3'd0;
            sayi_q         <= 2'd0;
            bas_gecerli_q  <= 1'b0;
            arka_gecerli_q <= 1'b0;
            yaz_yazmac_q   <= 1'b0;
            yaz_adres_q    <= 5'd0;
            yaz_deger_q    <= 32'd0;
        end else begin
            durum_q        <= durum_d;
            sayac_q        <= sayac_d;
            sayi_q         <= sayi_d;
            bas_gecerli_q  <= bas_gecerli_d;
            arka_gecerli_q <= arka_gecerli_d;
            yaz_yazmac_q   <= yaz_yazmac_d;
            yaz_adres_q    <= yaz_adres_d;
            yaz_deger_q    <= yaz_deger_d;
        end
    end

    // NOTE: queue payload needs no reset; the valid bits alone decide whether it is ever used.
    always_ff @(posedge clk_i) begin
        bas_q  <= bas_d;
        arka_q <= arka_d;
    end

endmodule

// File: tb/tb_geri_yaz_hakem.sv
// Directed bench for geri_yaz_hakem: pipeline priority, queued long results, stall,
// invalidation and mid-operation reset, each checked against hand-computed values.
module tb_geri_yaz_hakem;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        gy_gecerli_i;
    logic [4:0]  gy_adres_i;
    logic [31:0] gy_deger_i;
    logic        uzun_gecerli_i;
    logic [4:0]  uzun_adres_i;
    logic [31:0] uzun_deger_i;
    logic        uzun_hazir_o;
    logic [4:0]  cz_rs1_adres_i;
    logic [4:0]  cz_rs2_adres_i;
    logic        cz_bekliyor_o;
    logic        cyo_durdur_o;
    logic [4:0]  cyo_yaz_adres_o;
    logic [31:0] cyo_yaz_deger_o;
    logic        cyo_yaz_yazmac_o;

    int n_checks = 0;
    int n_errors = 0;

    geri_yaz_hakem #(.BEKLEME_ESIGI(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .gy_gecerli_i     (gy_gecerli_i),
        .gy_adres_i       (gy_adres_i),
        .gy_deger_i       (gy_deger_i),
        .uzun_gecerli_i   (uzun_gecerli_i),
        .uzun_adres_i     (uzun_adres_i),
        .uzun_deger_i     (uzun_deger_i),
        .uzun_hazir_o     (uzun_hazir_o),
        .cz_rs1_adres_i   (cz_rs1_adres_i),
        .cz_rs2_adres_i   (cz_rs2_adres_i),
        .cz_bekliyor_o    (cz_bekliyor_o),
        .cyo_durdur_o     (cyo_durdur_o),
        .cyo_yaz_adres_o  (cyo_yaz_adres_o),
        .cyo_yaz_deger_o  (cyo_yaz_deger_o),
        .cyo_yaz_yazmac_o (cyo_yaz_yazmac_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gy(input logic v, input logic [4:0] a, input logic [31:0] d);
        gy_gecerli_i = v;
        gy_adres_i   = a;
        gy_deger_i   = d;
    endtask

    task automatic set_uzun(input logic v, input logic [4:0] a, input logic [31:0] d);
        uzun_gecerli_i = v;
        uzun_adres_i   = a;
        uzun_deger_i   = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_yazmac"},   32'(cyo_yaz_yazmac_o), 32'd0);
        check({tag, "_adres"},    32'(cyo_yaz_adres_o),  32'd0);
        check({tag, "_deger"},    cyo_yaz_deger_o,       32'd0);
        check({tag, "_durdur"},   32'(cyo_durdur_o),     32'd0);
        check({tag, "_hazir"},    32'(uzun_hazir_o),     32'd1);
        check({tag, "_bekliyor"}, 32'(cz_bekliyor_o),    32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        set_gy(1'b0, 5'd0, 32'd0);
        set_uzun(1'b0, 5'd0, 32'd0);
        cz_rs1_adres_i = 5'd0;
        cz_rs2_adres_i = 5'd0;
        #2;
        check_reset_outputs("rst");
        tick();
        tick();
        rst_i = 1'b0;

        // Pipeline-only traffic, then a write to x0 that must not be performed.
        set_gy(1'b1, 5'd6, 32'h0000_ffff);
        tick();
        check("gy_yazmac", 32'(cyo_yaz_yazmac_o), 32'd1);
        check("gy_adres",  32'(cyo_yaz_adres_o),  32'd6);
        check("gy_deger",  cyo_yaz_deger_o,       32'h0000_ffff);
        set_gy(1'b1, 5'd0, 32'hdead_beef);
        tick();
        check("x0_yazmac",     32'(cyo_yaz_yazmac_o), 32'd0);
        check("x0_adres_hold", 32'(cyo_yaz_adres_o),  32'd6);
        check("x0_deger_hold", cyo_yaz_deger_o,       32'h0000_ffff);
        set_gy(1'b0, 5'd0, 32'd0);

        // Long result with idle pipeline: push T, pop T+1, visible T+2.
        set_uzun(1'b1, 5'd5, 32'hffff_0000);
        cz_rs1_adres_i = 5'd5;
        #1;
        check("uz_T_hazir",    32'(uzun_hazir_o),  32'd1);
        check("uz_T_bekliyor", 32'(cz_bekliyor_o), 32'd0);
        tick();
        set_uzun(1'b0, 5'd0, 32'd0);
        #1;
        check("uz_T1_bekliyor", 32'(cz_bekliyor_o),    32'd1);
        check("uz_T1_yazmac",   32'(cyo_yaz_yazmac_o), 32'd0);
        tick();
        check("uz_T2_yazmac",   32'(cyo_yaz_yazmac_o), 32'd1);
        check("uz_T2_adres",    32'(cyo_yaz_adres_o),  32'd5);
        check("uz_T2_deger",    cyo_yaz_deger_o,       32'hffff_0000);
        check("uz_T2_bekliyor", 32'(cz_bekliyor_o),    32'd0);
        cz_rs1_adres_i = 5'd0;
        tick();
        check("uz_T3_yazmac", 32'(cyo_yaz_yazmac_o), 32'd0);

        // Long result addressed to x0 is accepted and discarded.
        set_uzun(1'b1, 5'd0, 32'h0000_1234);
        tick();
        set_uzun(1'b0, 5'd0, 32'd0);
        #1;
        check("uz0_hazir", 32'(uzun_hazir_o), 32'd1);
        tick();
        check("uz0_yazmac", 32'(cyo_yaz_yazmac_o), 32'd0);

        // Two pushes under a continuously busy pipeline: full, stall after 4 denials, in-order drain.
        set_gy(1'b1, 5'd1, 32'haaaa_5555);
        set_uzun(1'b1, 5'd10, 32'ha0a0_a0a0);
        tick();
        check("full_A_yazmac", 32'(cyo_yaz_yazmac_o), 32'd1);
        check("full_A_adres",  32'(cyo_yaz_adres_o),  32'd1);
        set_uzun(1'b1, 5'd11, 32'hb0b0_b0b0);
        #1;
        check("full_B_hazir", 32'(uzun_hazir_o), 32'd1);
        tick();
        set_uzun(1'b0, 5'd0, 32'd0);
        #1;
        check("full_C_hazir", 32'(uzun_hazir_o), 32'd0);
        tick();
        tick();
        check("stall_3_durdur", 32'(cyo_durdur_o), 32'd0);
        tick();
        check("stall_4_durdur", 32'(cyo_durdur_o), 32'd1);
        set_gy(1'b0, 5'd0, 32'd0);
        tick();
        check("drain1_yazmac", 32'(cyo_yaz_yazmac_o), 32'd1);
        check("drain1_adres",  32'(cyo_yaz_adres_o),  32'd10);
        check("drain1_deger",  cyo_yaz_deger_o,       32'ha0a0_a0a0);
        check("drain1_durdur", 32'(cyo_durdur_o),     32'd0);
        tick();
        check("drain2_adres",  32'(cyo_yaz_adres_o),  32'd11);
        check("drain2_deger",  cyo_yaz_deger_o,       32'hb0b0_b0b0);
        check("drain2_hazir",  32'(uzun_hazir_o),     32'd1);
        tick();
        check("drain3_yazmac", 32'(cyo_yaz_yazmac_o), 32'd0);

        // Pending x7 entry overwritten by a younger pipeline write to x7.
        set_gy(1'b1, 5'd1, 32'haaaa_5555);
        set_uzun(1'b1, 5'd7, 32'h7777_0000);
        tick();
        set_uzun(1'b0, 5'd0, 32'd0);
        set_gy(1'b1, 5'd7, 32'h1234_5678);
        cz_rs2_adres_i = 5'd7;
        #1;
        check("inv_bekliyor_pre", 32'(cz_bekliyor_o), 32'd1);
        tick();
        check("inv_yazmac",        32'(cyo_yaz_yazmac_o), 32'd1);
        check("inv_adres",         32'(cyo_yaz_adres_o),  32'd7);
        check("inv_deger",         cyo_yaz_deger_o,       32'h1234_5678);
        check("inv_bekliyor_post", 32'(cz_bekliyor_o),    32'd0);
        set_gy(1'b0, 5'd0, 32'd0);
        tick();
        check("inv_no_stale1", 32'(cyo_yaz_yazmac_o), 32'd0);
        tick();
        check("inv_no_stale2", 32'(cyo_yaz_yazmac_o), 32'd0);
        cz_rs2_adres_i = 5'd0;

        // Push invalidated by a pipeline write to the same register in the same cycle.
        set_gy(1'b1, 5'd9, 32'h9999_0000);
        set_uzun(1'b1, 5'd9, 32'hdead_beef);
        tick();
        set_gy(1'b0, 5'd0, 32'd0);
        set_uzun(1'b0, 5'd0, 32'd0);
        check("same_deger", cyo_yaz_deger_o,   32'h9999_0000);
        check("same_hazir", 32'(uzun_hazir_o), 32'd1);
        tick();
        check("same_no_stale", 32'(cyo_yaz_yazmac_o), 32'd0);

        // Reset pulsed with two entries queued.
        set_gy(1'b1, 5'd1, 32'haaaa_5555);
        set_uzun(1'b1, 5'd12, 32'hcccc_0000);
        tick();
        set_uzun(1'b1, 5'd13, 32'hdddd_0000);
        tick();
        set_uzun(1'b0, 5'd0, 32'd0);
        cz_rs1_adres_i = 5'd12;
        #1;
        check("pre_rst_hazir",    32'(uzun_hazir_o),  32'd0);
        check("pre_rst_bekliyor", 32'(cz_bekliyor_o), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midrst");
        set_gy(1'b0, 5'd0, 32'd0);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_yazmac", 32'(cyo_yaz_yazmac_o), 32'd0);
        end
        check("post_rst_hazir",  32'(uzun_hazir_o),  32'd1);
        check("post_rst_durdur", 32'(cyo_durdur_o),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
